// File: rtl/mux_scan_pkg.sv
// Shared widths, FSM state type and scan direction for mux_scan_ctrl.
// Define MUX_SCAN_MSB_FIRST_EN to scan 7 down to 0; otherwise 0 up to 7.
package mux_scan_pkg;

    localparam int unsigned SEL_W    = 3;
    localparam int unsigned WORD_W   = 8;
    localparam int unsigned N_SEL    = 8;
    localparam int unsigned HOLD_MAX = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

`ifdef MUX_SCAN_MSB_FIRST_EN
    localparam logic SCAN_DIR = 1'b1;
`else
    localparam logic SCAN_DIR = 1'b0;
`endif

    // First select value of a scan, also the parked value after reset/abort
    localparam logic [SEL_W-1:0] SEL_START = SCAN_DIR ? SEL_W'(N_SEL - 1) : SEL_W'(0);

endpackage

// File: rtl/mux_scan_ctrl_sel_counter.sv
// Hold counter and select stepping. Strobe and last are registered look-ahead
// flags: strobe marks the final hold cycle, last marks that final cycle on the
// final select value. dir=1 steps downward.
module sel_counter
    import mux_scan_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step_en,
    input  logic             dir,
    output logic [SEL_W-1:0] sel,
    output logic             strobe,
    output logic             last
);

    localparam int unsigned     HOLD_W   = $clog2(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic            HOLD_ONE = (HOLD_CYCLES == 1);

    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_inc;
    logic [SEL_W-1:0]  start_val;
    logic [SEL_W-1:0]  end_val;
    logic [SEL_W-1:0]  sel_nxt;

    // Direction-dependent endpoints and next values
    always_comb begin
        start_val = dir ? SEL_W'(N_SEL - 1) : SEL_W'(0);
        end_val   = dir ? SEL_W'(0) : SEL_W'(N_SEL - 1);
        sel_nxt   = dir ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));
        hold_inc  = hold + HOLD_W'(1);
    end

    // load with step_en starts a scan; load alone parks at the start value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel    <= SEL_START;
            hold   <= '0;
            strobe <= 1'b0;
            last   <= 1'b0;
        end else if (load) begin
            sel    <= start_val;
            hold   <= '0;
            strobe <= step_en && HOLD_ONE;
            last   <= 1'b0;
        end else if (step_en) begin
            if (strobe) begin
                sel    <= sel_nxt;
                hold   <= '0;
                strobe <= HOLD_ONE;
                last   <= HOLD_ONE && (sel_nxt == end_val);
            end else begin
                hold   <= hold_inc;
                strobe <= (hold_inc == HOLD_END);
                last   <= (hold_inc == HOLD_END) && (sel == end_val);
            end
        end else begin
            strobe <= 1'b0;
            last   <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a latched 8-bit word through an external 8:1 mux by stepping its
// select lines, holding each value HOLD_CYCLES cycles.
// Define MUX_SCAN_MSB_FIRST_EN for a 7-to-0 scan (default 0-to-7).
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              abort,
    output logic [WORD_W-1:0] word,
    output logic [SEL_W-1:0]  sel,
    output logic              sel_valid,
    output logic              bit_strobe,
    output logic              done
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > HOLD_MAX) begin : g_bad_hold
        $error("mux_scan_ctrl: HOLD_CYCLES out of range 1..16");
    end

    scan_state_t state;
    logic        accept;
    logic        cnt_load;
    logic        cnt_step;
    logic        cnt_last;

    // Handshake and counter control decoded from registered state
    always_comb begin
        accept   = 1'b0;
        cnt_load = 1'b0;
        cnt_step = 1'b0;
        accept   = (state == IDLE) && din_valid && din_ready && !abort;
        if (accept) begin
            cnt_load = 1'b1;
            cnt_step = 1'b1;
        end else if (state == SCAN) begin
            if (abort) begin
                cnt_load = 1'b1;
            end else if (!(bit_strobe && cnt_last)) begin
                cnt_step = 1'b1;
            end
        end
    end

    sel_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_sel_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .step_en (cnt_step),
        .dir     (SCAN_DIR),
        .sel     (sel),
        .strobe  (bit_strobe),
        .last    (cnt_last)
    );

    // Scan FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word      <= '0;
            din_ready <= 1'b0;
            sel_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    din_ready <= 1'b1;
                    sel_valid <= 1'b0;
                    if (accept) begin
                        state     <= SCAN;
                        word      <= din;
                        din_ready <= 1'b0;
                        sel_valid <= 1'b1;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state     <= IDLE;
                        din_ready <= 1'b1;
                        sel_valid <= 1'b0;
                    end else if (bit_strobe && cnt_last) begin
                        state     <= DONE;
                        sel_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    din_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    din_ready <= 1'b0;
                    sel_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1: cycles each select value is held; legal range 1..16.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port din  input  8  parallel word to be scanned.
REQ-005 SHALL have port din_valid  input  1  din is presented.
REQ-006 SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current scan.
REQ-008 SHALL have port word  output  8  latched word, driven to the 8:1 mux data inputs.
REQ-009 SHALL have port sel  output  3  select value, driven to the 8:1 mux select inputs.
REQ-010 SHALL have port sel_valid  output  1  sel/word are meaningful (scan in progress).
REQ-011 SHALL have port bit_strobe  output  1  last hold cycle of the current sel value.
REQ-012 SHALL have port done  output  1  one-cycle pulse after a completed, non-aborted scan.

Function
REQ-013 SHALL implement the states IDLE, SCAN and DONE.
REQ-014 IDLE SHALL drive din_ready=1, sel_valid=0 and bit_strobe=0.
REQ-015 A transfer SHALL occur when din_valid=1, din_ready=1 and abort=0; on that edge word<=din, sel<=start value, hold counter<=0, state<=SCAN.
REQ-016 SCAN SHALL drive din_ready=0 and sel_valid=1; word SHALL stay constant for the whole scan.
REQ-017 Each sel value SHALL be held for exactly HOLD_CYCLES cycles; bit_strobe=1 on the final cycle of each hold.
REQ-018 On a bit_strobe cycle that is not the last sel value, sel SHALL step by one (wrap-free) and the hold counter SHALL clear.
REQ-019 On the bit_strobe cycle of the last sel value, state SHALL go to DONE; total SCAN length = 8*HOLD_CYCLES cycles.
REQ-020 DONE SHALL last one cycle with done=1, din_ready=0, sel_valid=0, then go to IDLE; back-to-back words therefore have a 1-cycle gap plus the IDLE accept cycle.
REQ-021 In IDLE and DONE, sel and word SHALL hold their last values.
REQ-022 abort=1 in SCAN SHALL force IDLE on the next edge with no done pulse and sel reset to the start value; abort in IDLE or DONE SHALL have no effect other than blocking acceptance (REQ-015).
REQ-023 abort and bit_strobe of the last sel in the same cycle: abort SHALL win (no done).
REQ-024 din_valid while din_ready=0 SHALL be ignored; the upstream holds data until accepted.

Reset
REQ-025 While rst_n=0, outputs SHALL be asynchronously forced to state=IDLE, word=8'h00, sel=start value, sel_valid=0, bit_strobe=0, done=0 and din_ready=0.
REQ-026 din_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-027 Reset asserted mid-SCAN SHALL discard the scan with no done pulse.

Configuration
REQ-028 With macro MUX_SCAN_MSB_FIRST_EN defined, the start value SHALL be 3'd7 and sel SHALL decrement to 3'd0.
REQ-029 Without MUX_SCAN_MSB_FIRST_EN, the start value SHALL be 3'd0 and sel SHALL increment to 3'd7.

Structure
REQ-030 Package mux_scan_pkg SHALL hold SEL_W=3, WORD_W=8, N_SEL=8, HOLD_MAX=16 and the state typedef scan_state_t.
REQ-031 Sub-module sel_counter SHALL contain the hold counter and sel stepping, with inputs load, step_en and dir, and outputs sel and last.
REQ-032 The FSM and handshake SHALL stay in mux_scan_ctrl; the 8:1 mux is external.

Verification
REQ-033 Reset check: rst_n=0 mid-SCAN -> outputs immediately take the REQ-025 values; din_ready=1 one edge after release.
REQ-034 Basic scan: HOLD_CYCLES=1, din=8'hA5 accepted -> sel 0..7 on consecutive cycles, bit_strobe=1 on each, done pulse on cycle 9; a modelled mux output gives 1,0,1,0,0,1,0,1.
REQ-035 Hold timing: HOLD_CYCLES=3, din=8'h3C -> each sel is held 3 cycles, bit_strobe on every 3rd cycle, done after 24 SCAN cycles.
REQ-036 Abort: abort pulsed while sel=4 -> IDLE next cycle, no done, din_ready=1; abort together with the last strobe -> no done.
REQ-037 Handshake: din_valid held high with 8'h11 then 8'h22 -> second word accepted only after DONE; word never changes during SCAN.
REQ-038 Macro: rebuild with MUX_SCAN_MSB_FIRST_EN, din=8'h80 -> sel 7..0, mux output 1 followed by seven 0s.
